// File: rtl/timekeeper_core_if.sv
// timekeeper_core_if
//  Groups the timebase control inputs and the time/strobe outputs of
//  timekeeper_core.
//  master : the controller side. It drives set_sw, time_btn_t and tz_offset and
//           observes the time values.
//  slave  : the timebase core. It receives the controls and drives the time values.
//  Signals: set_sw, time_btn_t[2:0], tz_offset[4:0] (signed hours), tick_1hz,
//           day_rollover, utc_hour_val, local_hour_val, cur_min_val,
//           cur_sec_val, and the BCD digits h/m/s tens/ones.
`timescale 1ns/1ps
interface timekeeper_core_if;
  logic       set_sw;
  logic [2:0] time_btn_t;
  logic [4:0] tz_offset;
  logic       tick_1hz;
  logic       day_rollover;
  logic [5:0] utc_hour_val;
  logic [5:0] local_hour_val;
  logic [5:0] cur_min_val;
  logic [5:0] cur_sec_val;
  logic [3:0] h_tens;
  logic [3:0] h_ones;
  logic [3:0] m_tens;
  logic [3:0] m_ones;
  logic [3:0] s_tens;
  logic [3:0] s_ones;

  modport master (
    output set_sw, time_btn_t, tz_offset,
    input  tick_1hz, day_rollover, utc_hour_val, local_hour_val, cur_min_val,
           cur_sec_val, h_tens, h_ones, m_tens, m_ones, s_tens, s_ones
  );

  modport slave (
    input  set_sw, time_btn_t, tz_offset,
    output tick_1hz, day_rollover, utc_hour_val, local_hour_val, cur_min_val,
           cur_sec_val, h_tens, h_ones, m_tens, m_ones, s_tens, s_ones
  );
endinterface

// File: rtl/timekeeper_core.sv
// timekeeper_core
//  Free-running HH:MM:SS timebase. It divides clk_1k down to a 1 Hz strobe and
//  keeps UTC time. A signed timezone offset is applied to produce the local hour.
//  In set mode, pulse buttons adjust each field with no carry into the next field.
//  Ports:
//   clk_1k : system clock, all logic on the rising edge
//   rst    : asynchronous active-high reset
//   bus    : timekeeper_core_if.slave
//            controls: set_sw, time_btn_t, tz_offset
//            outputs : strobes, UTC/local hour, min, sec, BCD digits
`timescale 1ns/1ps
module timekeeper_core #(
  parameter int CLK_HZ  = 1000,
  parameter int PRESC_W = 10
) (
  input  logic                 clk_1k,
  input  logic                 rst,
  timekeeper_core_if.slave     bus
);

  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc;
  logic [5:0]         hour;
  logic [5:0]         min;
  logic [5:0]         sec;
  logic               tick;
  logic               rollover;

  logic signed [6:0]  tz_ext;
  logic signed [6:0]  tz_eff;
  logic signed [6:0]  local_sum;
  logic signed [6:0]  local_adj;
  logic [5:0]         local_hour;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    logic [5:0] t;
    t = v / 6'd10;
    return t[3:0];
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    logic [5:0] t;
    t = v % 6'd10;
    return t[3:0];
  endfunction

  // Prescaler, time-of-day counters and the one-cycle strobes
  always_ff @(posedge clk_1k or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      hour     <= 6'd0;
      min      <= 6'd0;
      sec      <= 6'd0;
      tick     <= 1'b0;
      rollover <= 1'b0;
    end else if (bus.set_sw) begin
      // Set mode: the partial second is discarded. Each button bumps only its own field.
      presc    <= '0;
      tick     <= 1'b0;
      rollover <= 1'b0;
      if (bus.time_btn_t[0]) hour <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
      if (bus.time_btn_t[1]) min  <= (min  == 6'd59) ? 6'd0 : min  + 6'd1;
      if (bus.time_btn_t[2]) sec  <= (sec  == 6'd59) ? 6'd0 : sec  + 6'd1;
    end else if (presc == PRESC_MAX) begin
      // Second boundary. The strobe and the new time become visible in the same cycle.
      presc    <= '0;
      tick     <= 1'b1;
      rollover <= (hour == 6'd23) && (min == 6'd59) && (sec == 6'd59);
      if (sec == 6'd59) begin
        sec <= 6'd0;
        if (min == 6'd59) begin
          min  <= 6'd0;
          hour <= (hour == 6'd23) ? 6'd0 : hour + 6'd1;
        end else begin
          min <= min + 6'd1;
        end
      end else begin
        sec <= sec + 6'd1;
      end
    end else begin
      presc    <= presc + {{(PRESC_W-1){1'b0}}, 1'b1};
      tick     <= 1'b0;
      rollover <= 1'b0;
    end
  end

  // Local hour = (utc + offset) mod 24. An out-of-range offset counts as zero.
  always_comb begin
    tz_ext = {{2{bus.tz_offset[4]}}, bus.tz_offset};
    if ((tz_ext < -7'sd12) || (tz_ext > 7'sd14)) begin
      tz_eff = 7'sd0;
    end else begin
      tz_eff = tz_ext;
    end
    local_sum = $signed({1'b0, hour}) + tz_eff;
    if (local_sum < 7'sd0) begin
      local_adj = local_sum + 7'sd24;
    end else if (local_sum >= 7'sd24) begin
      local_adj = local_sum - 7'sd24;
    end else begin
      local_adj = local_sum;
    end
    local_hour = local_adj[5:0];
  end

  assign bus.tick_1hz       = tick;
  assign bus.day_rollover   = rollover;
  assign bus.utc_hour_val   = hour;
  assign bus.local_hour_val = local_hour;
  assign bus.cur_min_val    = min;
  assign bus.cur_sec_val    = sec;
  assign bus.h_tens         = bcd_tens(local_hour);
  assign bus.h_ones         = bcd_ones(local_hour);
  assign bus.m_tens         = bcd_tens(min);
  assign bus.m_ones         = bcd_ones(min);
  assign bus.s_tens         = bcd_tens(sec);
  assign bus.s_ones         = bcd_ones(sec);

endmodule

// File: tb/tb_timekeeper_core.sv
// tb_timekeeper_core
//  Directed self-checking bench for timekeeper_core. It drives the controls through
//  the interface and compares the time outputs with hand-computed values.
`timescale 1ns/1ps
module tb_timekeeper_core;
  localparam int CLK_HZ = 1000;

  logic clk_1k;
  logic rst;
  int   n_checks;
  int   n_fail;

  timekeeper_core_if bus ();

  timekeeper_core #(.CLK_HZ(CLK_HZ), .PRESC_W(10)) dut (
    .clk_1k (clk_1k),
    .rst    (rst),
    .bus    (bus)
  );

  initial clk_1k = 1'b0;
  always #5 clk_1k = ~clk_1k;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk_1k);
    #1;
  endtask

  task automatic pulse(input logic [2:0] bits, input int n);
    for (int k = 0; k < n; k++) begin
      bus.time_btn_t = bits;
      step();
      bus.time_btn_t = 3'b000;
      step();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hour"}, {26'd0, bus.utc_hour_val}, h);
    check({tag, "_min"},  {26'd0, bus.cur_min_val},  m);
    check({tag, "_sec"},  {26'd0, bus.cur_sec_val},  s);
  endtask

  initial begin
    int ticks;
    int rolls;
    int first_tick;
    int seen;

    n_checks = 0;
    n_fail   = 0;
    rst            = 1'b1;
    bus.set_sw     = 1'b0;
    bus.time_btn_t = 3'b000;
    bus.tz_offset  = 5'd0;
    #2;
    check("rst_tick", {31'd0, bus.tick_1hz}, 0);
    check("rst_roll", {31'd0, bus.day_rollover}, 0);
    check_time("rst", 0, 0, 0);
    check("rst_local", {26'd0, bus.local_hour_val}, 0);
    bus.tz_offset = 5'd3;
    #1;
    check("rst_local_tz3", {26'd0, bus.local_hour_val}, 3);
    bus.tz_offset = 5'd0;
    step();
    rst = 1'b0;

    // 1: three ticks spaced CLK_HZ apart, one cycle each
    ticks = 0;
    for (int i = 1; i <= 3 * CLK_HZ; i++) begin
      step();
      if (bus.tick_1hz) begin
        ticks++;
        check("t1_tick_pos", i, ticks * CLK_HZ);
      end
      if (i == 3 * CLK_HZ) check("t1_sec3", {26'd0, bus.cur_sec_val}, 3);
    end
    check("t1_tick_count", ticks, 3);
    step();
    check("t1_tick_width", {31'd0, bus.tick_1hz}, 0);

    // 2: 23:59:58 -> two ticks -> 00:00:00 with rollover on the second tick only
    do_reset();
    bus.set_sw = 1'b1;
    pulse(3'b001, 23);
    pulse(3'b010, 59);
    pulse(3'b100, 58);
    check_time("t2_set", 23, 59, 58);
    bus.set_sw = 1'b0;
    rolls = 0;
    for (int i = 1; i <= 2 * CLK_HZ; i++) begin
      step();
      if (bus.day_rollover) rolls++;
      if (i == CLK_HZ) begin
        check("t2_tick1", {31'd0, bus.tick_1hz}, 1);
        check("t2_roll1", {31'd0, bus.day_rollover}, 0);
        check_time("t2_after1", 23, 59, 59);
      end
      if (i == 2 * CLK_HZ) begin
        check("t2_roll2", {31'd0, bus.day_rollover}, 1);
        check_time("t2_after2", 0, 0, 0);
      end
    end
    check("t2_roll_count", rolls, 1);
    step();
    check("t2_roll_width", {31'd0, bus.day_rollover}, 0);

    // 3: sixty second pulses in set mode wrap sec with no carry and no tick
    do_reset();
    bus.set_sw = 1'b1;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      bus.time_btn_t = 3'b100;
      step();
      bus.time_btn_t = 3'b000;
      if (bus.tick_1hz) seen++;
      if (k == 58) check("t3_sec59", {26'd0, bus.cur_sec_val}, 59);
      step();
      if (bus.tick_1hz) seen++;
    end
    check_time("t3", 0, 0, 0);
    check("t3_no_tick", seen, 0);

    // 4: timezone arithmetic
    pulse(3'b001, 2);
    bus.tz_offset = 5'b11011;  // -5
    #1;
    check("t4_local_m5", {26'd0, bus.local_hour_val}, 21);
    check("t4_h_tens", {28'd0, bus.h_tens}, 2);
    check("t4_h_ones", {28'd0, bus.h_ones}, 1);
    check("t4_utc_kept", {26'd0, bus.utc_hour_val}, 2);
    pulse(3'b001, 20);
    bus.tz_offset = 5'd14;
    #1;
    check("t4_local_p14", {26'd0, bus.local_hour_val}, 12);
    pulse(3'b001, 4);
    bus.tz_offset = 5'b10000;  // -16, out of range
    #1;
    check("t4_local_m16", {26'd0, bus.local_hour_val}, 2);
    bus.tz_offset = 5'b10011;  // -13, out of range
    #1;
    check("t4_local_m13", {26'd0, bus.local_hour_val}, 2);
    bus.tz_offset = 5'b10100;  // -12, in range
    #1;
    check("t4_local_m12", {26'd0, bus.local_hour_val}, 14);
    bus.tz_offset = 5'd0;

    // 5: reset in the middle of a second at 10:20:30
    do_reset();
    bus.set_sw = 1'b1;
    pulse(3'b111, 10);
    pulse(3'b110, 10);
    pulse(3'b100, 10);
    check_time("t5_set", 10, 20, 30);
    #1;
    check("t5_h_tens", {28'd0, bus.h_tens}, 1);
    check("t5_m_tens", {28'd0, bus.m_tens}, 2);
    check("t5_s_tens", {28'd0, bus.s_tens}, 3);
    check("t5_s_ones", {28'd0, bus.s_ones}, 0);
    bus.set_sw = 1'b0;
    for (int i = 0; i < 500; i++) step();
    #2;
    rst = 1'b1;
    #1;
    check_time("t5_async", 0, 0, 0);
    check("t5_s_tens0", {28'd0, bus.s_tens}, 0);
    step();
    rst = 1'b0;
    first_tick = 0;
    for (int i = 1; i <= CLK_HZ + 500 && first_tick == 0; i++) begin
      step();
      if (bus.tick_1hz) first_tick = i;
    end
    check("t5_first_tick", first_tick, CLK_HZ);

    // run mode ignores buttons
    pulse(3'b111, 3);
    check_time("t5_btn_ignored", 0, 0, 1);

    // 6: simultaneous hour and sec pulses from 05:00:59
    do_reset();
    bus.set_sw = 1'b1;
    pulse(3'b001, 5);
    pulse(3'b100, 59);
    check_time("t6_set", 5, 0, 59);
    pulse(3'b101, 1);
    check_time("t6", 6, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
